weight_bit_scanner: RTL and testbench
=====================================

// Module: weight_bit_scanner
// PURPOSE
// - Bit-sparsity front end of the bit-serial PE: accepts one sign-magnitude weight per handshake and
//   emits the position of each set magnitude bit, one per cycle, MSB-first, as a 3-bit index.
// - Directly upstream of decoder_3to7: out_idx drives its `in`; (out_val & ~out_zero) drives its `val`.
// - Zero bits are skipped; cycles per weight = popcount(mag), or 1 for an all-zero weight.
// PARAMETERS
// - MAG_WIDTH  7  magnitude bits per weight (sign carried separately)
// - IDX_WIDTH  3  index width = $clog2(MAG_WIDTH)
// - MAX_TERMS  7  max indices emitted per weight, 1..MAG_WIDTH; lower set bits beyond it are dropped
// PORTS
// - clk        in   1          clock, rising edge
// - reset      in   1          asynchronous, active-high
// - w_val      in   1          input weight valid
// - w_rdy      out  1          block can accept a weight this cycle
// - w_mag      in   MAG_WIDTH  weight magnitude
// - w_sign     in   1          weight sign (1 = negative)
// - out_val    out  1          index beat valid
// - out_rdy    in   1          downstream accepts beat
// - out_idx    out  IDX_WIDTH  bit position of current term (0 = LSB)
// - out_sign   out  1          sign of the weight being scanned, constant across its beats
// - out_last   out  1          final beat of this weight
// - out_zero   out  1          weight magnitude was zero; beat carries no term
// BEHAVIOUR
// - Reset (async, any time incl. mid-scan): state=IDLE, mask=0, term_cnt=0, sign=0; outputs
//   w_rdy=0 while reset high, then 1; out_val=0, out_idx=0, out_sign=0, out_last=0, out_zero=0.
//   A partially scanned weight is discarded; no beat of it appears after reset.
// - States: IDLE (no weight held), SCAN (weight held in mask register).
// - w_rdy = (state==IDLE) | (out_val & out_rdy & out_last)  -> back-to-back weights, no bubble.
// - Accept (w_val & w_rdy): mask<=w_mag, sign<=w_sign, zero_r<=(w_mag==0), term_cnt<=0, state<=SCAN.
// - SCAN: out_val=1; out_idx = index of highest set bit of mask (registered mask, comb encode);
//   out_zero=zero_r; out_idx=0 when zero_r.
// - out_last = zero_r | (mask with top bit cleared ==0) | (term_cnt == MAX_TERMS-1).
// - Beat handshake (out_val & out_rdy): clear top bit of mask, term_cnt++; if out_last: state<=IDLE
//   unless a new weight is accepted the same cycle (accept wins, reloads registers, stays SCAN).
// - out_rdy low: all outputs hold stable; out_val never drops without handshake.
// - Latency: weight accepted at edge N -> first beat valid in cycle N+1. Throughput 1 beat/cycle.
// - w_val with w_rdy=0: ignored; upstream must hold (standard val/rdy).
// - Index never exceeds MAG_WIDTH-1; out_idx=7 is never produced for MAG_WIDTH=7.
// STRUCTURE
// - Package bitsim_pkg: MAG_WIDTH/IDX_WIDTH localparams, scan_state_t enum {IDLE, SCAN}.
// - Sub-module msb_priority_enc (MAG_WIDTH in -> IDX_WIDTH idx + any): combinational,
//   instantiated once on the mask register; FSM, mask, counter in this module.
// TESTING
// - Reset, then w_mag=7'b1010010, w_sign=1, out_rdy=1 -> idx 6,4,1 in 3 consecutive cycles,
//   out_sign=1, out_last only on idx 1, out_zero=0.
// - w_mag=0 -> single beat out_val=1, out_zero=1, out_last=1, out_idx=0; decoder val stays 0.
// - Two weights back-to-back (7'b0000001 then 7'b1000000), w_val held -> second accepted on
//   the last beat of first; beats idx 0 then 6 with no idle cycle between.
// - MAX_TERMS=2, w_mag=7'b1111111 -> idx 6,5 only, last on 5; then IDLE, w_rdy=1.
// - out_rdy toggled randomly on w_mag=7'b0110101 -> idx/last/sign stable while stalled; sequence 5,4,2,0.
// - Assert reset async mid-scan of 7'b1110000 after first beat -> out_val=0 immediately, no
//   further beats; next weight 7'b0000100 yields single beat idx 2, last.

Source files
------------

// File: rtl/weight_bit_scanner_pkg.sv
// Shared constants and types for the bit-serial PE weight scanner.
package bitsim_pkg;

    localparam int MAG_WIDTH = 7;
    localparam int IDX_WIDTH = $clog2(MAG_WIDTH);

    typedef enum logic {
        IDLE,
        SCAN
    } scan_state_t;

    // Weight as held while its set bits are being walked.
    typedef struct packed {
        logic [MAG_WIDTH-1:0] mag;
        logic                 sign;
        logic                 zero;
    } weight_t;

endpackage

// File: rtl/weight_bit_scanner_if.sv
// Weight-in / index-out handshake bundle for weight_bit_scanner.
interface weight_bit_scanner_if;
    import bitsim_pkg::*;

    logic                 w_val;
    logic                 w_rdy;
    logic [MAG_WIDTH-1:0] w_mag;
    logic                 w_sign;

    logic                 out_val;
    logic                 out_rdy;
    logic [IDX_WIDTH-1:0] out_idx;
    logic                 out_sign;
    logic                 out_last;
    logic                 out_zero;

    modport master (
        output w_val, w_mag, w_sign, out_rdy,
        input  w_rdy, out_val, out_idx, out_sign, out_last, out_zero
    );

    modport slave (
        input  w_val, w_mag, w_sign, out_rdy,
        output w_rdy, out_val, out_idx, out_sign, out_last, out_zero
    );

endinterface

// File: rtl/weight_bit_scanner_msb_priority_enc.sv
// Combinational MSB-first priority encoder: index of the highest set bit.
module msb_priority_enc #(
    parameter int W  = 7,
    parameter int IW = 3
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        idx = '0;
        any = |vec;
        // Ascending scan, so the highest set bit is the last to write idx.
        for (int i = 0; i < W; i++) begin
            if (vec[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/weight_bit_scanner.sv
// Bit-sparsity front end: walks the set magnitude bits of each weight MSB-first,
// one index beat per cycle, skipping zero bits.
module weight_bit_scanner
    import bitsim_pkg::*;
#(
    parameter int MAX_TERMS = 7
) (
    input  logic          clk,
    input  logic          reset,
    weight_bit_scanner_if.slave bus
);

    localparam int CNT_W = $clog2(MAG_WIDTH + 1);

    scan_state_t          state_q, state_d;
    weight_t              w_q, w_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [IDX_WIDTH-1:0] top_idx;
    logic                 top_any;
    logic [MAG_WIDTH-1:0] top_bit;
    logic [MAG_WIDTH-1:0] rest;
    logic                 scan, last, beat, rdy, accept;

    msb_priority_enc #(
        .W  (MAG_WIDTH),
        .IW (IDX_WIDTH)
    ) u_enc (
        .vec (w_q.mag),
        .idx (top_idx),
        .any (top_any)
    );

    assign top_bit = MAG_WIDTH'(top_any) << top_idx;
    assign rest    = w_q.mag & ~top_bit;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;

        scan   = (state_q == SCAN);
        last   = scan & (w_q.zero | (rest == '0) | (cnt_q == CNT_W'(MAX_TERMS - 1)));
        beat   = scan & bus.out_rdy;
        // Ready on the last beat too, so consecutive weights stream without a bubble.
        rdy    = ~reset & (~scan | (beat & last));
        accept = bus.w_val & rdy;

        if (beat) begin
            w_d.mag = rest;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last) state_d = IDLE;
        end
        if (accept) begin
            w_d.mag  = bus.w_mag;
            w_d.sign = bus.w_sign;
            w_d.zero = (bus.w_mag == '0);
            cnt_d    = '0;
            state_d  = SCAN;
        end
    end

    assign bus.w_rdy    = rdy;
    assign bus.out_val  = scan;
    assign bus.out_idx  = (scan & ~w_q.zero) ? top_idx : '0;
    assign bus.out_sign = scan & w_q.sign;
    assign bus.out_zero = scan & w_q.zero;
    assign bus.out_last = last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_weight_bit_scanner.sv
// Bench for weight_bit_scanner: directed table, multi-cycle corner sequences, random vs model.
module tb_weight_bit_scanner;
    import bitsim_pkg::*;

    localparam int MT1 = 7;

    typedef struct {
        logic [6:0] mag;
        logic       sign;
        int         nb;
        logic [2:0] idx [7];
    } vec_t;

    typedef struct {
        logic [2:0] idx;
        logic       zero;
        logic       sign;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    vec_t  vecs [6];
    beat_t q [$];
    int    stall_seq [4];

    always #5 clk = ~clk;

    weight_bit_scanner_if bus ();
    weight_bit_scanner_if bus2 ();

    assign bus2.w_val   = bus.w_val;
    assign bus2.w_mag   = bus.w_mag;
    assign bus2.w_sign  = bus.w_sign;
    assign bus2.out_rdy = bus.out_rdy;

    weight_bit_scanner #(.MAX_TERMS(MT1)) dut  (.clk(clk), .reset(reset), .bus(bus));
    weight_bit_scanner #(.MAX_TERMS(2))   dut2 (.clk(clk), .reset(reset), .bus(bus2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] m, input logic s, input int nb,
                                input int e0 = 0, e1 = 0, e2 = 0, e3 = 0, e4 = 0, e5 = 0, e6 = 0);
        vec_t r;
        r.mag = m; r.sign = s; r.nb = nb;
        r.idx[0] = 3'(e0); r.idx[1] = 3'(e1); r.idx[2] = 3'(e2); r.idx[3] = 3'(e3);
        r.idx[4] = 3'(e4); r.idx[5] = 3'(e5); r.idx[6] = 3'(e6);
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; bus.w_val = 1'b0; bus.out_rdy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Offer one weight with out_rdy=1 and compare the beat train against the table row.
    task automatic run_vec(input vec_t v);
        int k = 0;
        bit acc = 0;
        bit done = 0;
        @(negedge clk);
        bus.w_val = 1'b1; bus.w_mag = v.mag; bus.w_sign = v.sign; bus.out_rdy = 1'b1;
        for (int c = 0; c < 12 && !done; c++) begin
            #1;
            if (acc) begin
                chk("vec_val", bus.out_val, 1);
                if (bus.out_val) begin
                    if (k < v.nb) begin
                        chk("vec_idx", bus.out_idx, v.idx[k]);
                        chk("vec_last", bus.out_last, (k == v.nb - 1));
                    end else begin
                        chk("vec_extra_beat", k, v.nb - 1);
                    end
                    chk("vec_zero", bus.out_zero, (v.mag == 0));
                    chk("vec_sign", bus.out_sign, v.sign);
                    chk("vec_dec_val", bus.out_val & ~bus.out_zero, (v.mag != 0));
                    done = bus.out_last;
                    k++;
                end
            end
            if (bus.w_val && bus.w_rdy) acc = 1;
            @(negedge clk);
            if (acc) bus.w_val = 1'b0;
        end
        chk("vec_beats", k, v.nb);
    endtask

    task automatic model_push(input logic [6:0] m, input logic s);
        int n = 0;
        beat_t b;
        for (int i = 6; i >= 0; i--) begin
            if (m[i] && n < MT1) begin
                b.idx = 3'(i); b.zero = 1'b0; b.sign = s;
                q.push_back(b);
                n++;
            end
        end
        if (n == 0) begin
            b.idx = 3'd0; b.zero = 1'b1; b.sign = s;
            q.push_back(b);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int  k;
        bit  done, prev_stall, hold, exp_val, exp_rdy;
        logic [2:0] p_idx;
        logic p_last, p_sign;

        vecs[0] = mk(7'b1010010, 1'b1, 3, 6, 4, 1);
        vecs[1] = mk(7'b0000000, 1'b0, 1, 0);
        vecs[2] = mk(7'b0110101, 1'b0, 4, 5, 4, 2, 0);
        vecs[3] = mk(7'b1111111, 1'b1, 7, 6, 5, 4, 3, 2, 1, 0);
        vecs[4] = mk(7'b0000100, 1'b1, 1, 2);
        vecs[5] = mk(7'b1000001, 1'b0, 2, 6, 0);
        stall_seq[0] = 5; stall_seq[1] = 4; stall_seq[2] = 2; stall_seq[3] = 0;

        bus.w_val = 1'b0; bus.w_mag = '0; bus.w_sign = 1'b0; bus.out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wrdy", bus.w_rdy, 0);
        chk("rst_val", bus.out_val, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_wrdy", bus.w_rdy, 1);
        chk("post_rst_val", bus.out_val, 0);
        chk("post_rst_idx", bus.out_idx, 0);
        chk("post_rst_sign", bus.out_sign, 0);
        chk("post_rst_last", bus.out_last, 0);
        chk("post_rst_zero", bus.out_zero, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back: second weight accepted on the last beat of the first.
        do_reset();
        @(negedge clk);
        bus.w_val = 1'b1; bus.w_mag = 7'b0000001; bus.w_sign = 1'b0; bus.out_rdy = 1'b1;
        #1 chk("b2b_rdy0", bus.w_rdy, 1);
        @(negedge clk);
        bus.w_mag = 7'b1000000;
        #1;
        chk("b2b_val1", bus.out_val, 1);
        chk("b2b_idx1", bus.out_idx, 0);
        chk("b2b_last1", bus.out_last, 1);
        chk("b2b_rdy1", bus.w_rdy, 1);
        @(negedge clk);
        bus.w_val = 1'b0;
        #1;
        chk("b2b_val2", bus.out_val, 1);
        chk("b2b_idx2", bus.out_idx, 6);
        chk("b2b_last2", bus.out_last, 1);
        @(negedge clk);
        #1 chk("b2b_idle", bus.out_val, 0);

        // MAX_TERMS=2 truncation on the second instance.
        do_reset();
        @(negedge clk);
        bus.w_val = 1'b1; bus.w_mag = 7'b1111111; bus.w_sign = 1'b0; bus.out_rdy = 1'b1;
        #1 chk("mt_rdy", bus2.w_rdy, 1);
        @(negedge clk);
        bus.w_val = 1'b0;
        #1;
        chk("mt_val0", bus2.out_val, 1);
        chk("mt_idx0", bus2.out_idx, 6);
        chk("mt_last0", bus2.out_last, 0);
        @(negedge clk);
        #1;
        chk("mt_val1", bus2.out_val, 1);
        chk("mt_idx1", bus2.out_idx, 5);
        chk("mt_last1", bus2.out_last, 1);
        @(negedge clk);
        #1;
        chk("mt_idle_val", bus2.out_val, 0);
        chk("mt_idle_rdy", bus2.w_rdy, 1);

        // Random backpressure: outputs must hold while stalled.
        do_reset();
        @(negedge clk);
        bus.w_val = 1'b1; bus.w_mag = 7'b0110101; bus.w_sign = 1'b1; bus.out_rdy = 1'b0;
        #1 chk("stall_acc_rdy", bus.w_rdy, 1);
        @(negedge clk);
        bus.w_val = 1'b0;
        k = 0; done = 0; prev_stall = 0; p_idx = '0; p_last = 0; p_sign = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            bus.out_rdy = (c > 40) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            chk("stall_val", bus.out_val, 1);
            if (prev_stall) begin
                chk("stall_hold_idx", bus.out_idx, p_idx);
                chk("stall_hold_last", bus.out_last, p_last);
                chk("stall_hold_sign", bus.out_sign, p_sign);
            end
            if (bus.out_rdy) begin
                if (k < 4) begin
                    chk("stall_idx", bus.out_idx, stall_seq[k]);
                    chk("stall_last", bus.out_last, (k == 3));
                    chk("stall_sign", bus.out_sign, 1);
                end
                done = bus.out_last;
                k++;
            end
            prev_stall = !bus.out_rdy;
            p_idx = bus.out_idx; p_last = bus.out_last; p_sign = bus.out_sign;
            @(negedge clk);
        end
        chk("stall_beats", k, 4);

        // Async reset mid-scan drops the remaining beats.
        bus.out_rdy = 1'b1;
        bus.w_val = 1'b1; bus.w_mag = 7'b1110000; bus.w_sign = 1'b0;
        @(negedge clk);
        bus.w_val = 1'b0;
        #1 chk("mid_idx0", bus.out_idx, 6);
        @(negedge clk);
        #1 chk("mid_idx1", bus.out_idx, 5);
        reset = 1'b1;
        #1;
        chk("mid_rst_val", bus.out_val, 0);
        chk("mid_rst_rdy", bus.w_rdy, 0);
        @(negedge clk);
        @(negedge clk);
        #1 chk("mid_rst_hold_val", bus.out_val, 0);
        reset = 1'b0;
        #1;
        chk("mid_rel_val", bus.out_val, 0);
        chk("mid_rel_rdy", bus.w_rdy, 1);
        @(negedge clk);
        #1 chk("mid_no_beat", bus.out_val, 0);
        run_vec(mk(7'b0000100, 1'b0, 1, 2));

        // Random traffic against the reference model.
        do_reset();
        q.delete();
        hold = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!hold) begin
                bus.w_val  = ($urandom_range(0, 2) != 0);
                bus.w_mag  = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom);
                bus.w_sign = 1'($urandom);
            end
            bus.out_rdy = ($urandom_range(0, 3) != 0);
            #1;
            exp_val = (q.size() != 0);
            exp_rdy = (q.size() == 0) || (q.size() == 1 && bus.out_rdy);
            chk("rnd_val", bus.out_val, exp_val);
            chk("rnd_wrdy", bus.w_rdy, exp_rdy);
            if (exp_val) begin
                chk("rnd_idx", bus.out_idx, q[0].idx);
                chk("rnd_last", bus.out_last, (q.size() == 1));
                chk("rnd_zero", bus.out_zero, q[0].zero);
                chk("rnd_sign", bus.out_sign, q[0].sign);
            end
            if (exp_val && bus.out_rdy) void'(q.pop_front());
            if (bus.w_val && exp_rdy) begin
                model_push(bus.w_mag, bus.w_sign);
                hold = 0;
            end else begin
                hold = bus.w_val;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
